reservation_station: RTL and testbench
======================================

// Module: reservation_station
// PURPOSE
//  Single-entry Tomasulo reservation station directly downstream of the issue/dispatch stage.
//  - Accepts one dispatched task when the dispatcher targets this station's RS tag.
//  - Holds both source operands and snoops the common data bus (CDB) for pending ones.
//  - Issues to its functional unit with a valid/ready handshake once both operands are ready.
//  - Reports BUSY back to the dispatcher, which uses one bit of its rs_busy vector per station.
// PARAMETERS
//  RS_ID   4   this station's RS_tag_type encoding; a dispatch is accepted only if DEST_RS == RS_ID
//  TAG_W   3   width of producer tags (RS_tag_type) carried on operands and the CDB
//  XLEN    32  operand/data width
// PORTS
//  CLK          in   1      clock, rising edge
//  RST          in   1      asynchronous, active-high reset
//  DISP_VALID   in   1      dispatcher presents a task this cycle
//  DEST_RS      in   TAG_W  target station of the presented task
//  DISP_OP      in   11     {opcode[6:0], func[3:0]}, carried to the FU unchanged
//  DISP_DST     in   TAG_W  tag this result will be broadcast under (normally RS_ID)
//  DISP_Q1/Q2   in   TAG_W  producer tag of src1/src2; meaningful only when DISP_R1/R2 = 0
//  DISP_R1/R2   in   1      src1/src2 value already available
//  DISP_V1/V2   in   XLEN   src1/src2 value; meaningful only when DISP_R1/R2 = 1
//  CDB_VALID    in   1      result broadcast valid
//  CDB_TAG      in   TAG_W  producer tag of the broadcast
//  CDB_DATA     in   XLEN   broadcast value
//  FU_READY     in   1      functional unit accepts the operands this cycle
//  FU_VALID     out  1      operands and op presented to the FU
//  FU_OP        out  11     latched op
//  FU_A/FU_B    out  XLEN   latched src1/src2 values
//  FU_DST       out  TAG_W  latched destination tag
//  BUSY         out  1      station occupied (state != IDLE)
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; operand ready bits 0; tags and values 0.
//  - FSM states and transitions:
//    - IDLE -> WAIT when DISP_VALID && DEST_RS==RS_ID, with either operand not ready after capture.
//    - IDLE -> READY on the same accept when both operands are ready after capture.
//    - WAIT -> READY once both ready bits are set.
//    - READY -> IDLE on FU_VALID && FU_READY.
//  - Accept condition: DISP_VALID && DEST_RS==RS_ID && state==IDLE.
//    - A dispatch that arrives while BUSY is ignored; the dispatcher must not send one.
//  - Capture on accept, per operand: if R=1, take V.
//    - Else if CDB_VALID && CDB_TAG==Q in that same cycle, take CDB_DATA and set ready (dispatch bypass).
//    - Else store Q and leave the operand not ready.
//  - Snoop in WAIT: each not-ready operand whose Q==CDB_TAG with CDB_VALID=1 captures CDB_DATA and
//    sets ready at the next edge. Both operands may capture from one broadcast (Q1==Q2).
//  - FU_VALID is a register: it is 1 exactly while state==READY.
//    - Dispatch-to-FU_VALID latency: 1 cycle with both operands ready; otherwise 1 cycle after the
//      last matching CDB edge.
//    - FU_OP/A/B/DST stay stable while FU_VALID=1 && FU_READY=0.
//  - BUSY: set at the accept edge, cleared at the handshake edge.
//    - No same-cycle reuse: an entry freed this edge accepts a new dispatch no earlier than the next cycle.
//  - CDB traffic in IDLE or READY, and tag mismatches, are ignored.
//  - RST asserted mid-operation returns the station to IDLE immediately; the held task is discarded.
// CONFIGURATION
//  RS_FLUSH_EN defined:
//    - Adds input FLUSH (1 bit, synchronous).
//    - FLUSH=1 forces state=IDLE and FU_VALID=0 at the next edge, overriding accept, snoop and handshake.
//    - FLUSH and a dispatch in the same cycle: the dispatch is dropped.
//  RS_FLUSH_EN undefined: no FLUSH port; the entry is cleared only by RST or an FU handshake.
// STRUCTURE
//  - cpu_types package: RS_tag_type (STORE_1..ALU_2, INVALID), opcode constants, rs_state_t enum
//    {IDLE, WAIT, READY}, operand_t struct {rdy, tag, val}.
//  - Sub-module rs_operand_slot, instantiated twice: holds one operand_t and does capture and CDB
//    snoop; outputs rdy and val.
// TESTING
//  1. Both ready: dispatch R1=R2=1, V1=5, V2=7 ->
//     BUSY=1 next cycle; FU_VALID=1 with A=5, B=7; FU_READY=1 -> BUSY=0 next cycle.
//  2. One pending: Q1=2, R1=0; 3 cycles later CDB(tag 2, 0x1234) ->
//     FU_VALID=1 on the following cycle with A=0x1234.
//  3. Dispatch bypass: CDB(tag 3, 0xAA) in the dispatch cycle, Q1=Q2=3 ->
//     READY next cycle, A=B=0xAA.
//  4. Backpressure: FU_READY=0 for 4 cycles ->
//     FU_VALID, A, B, OP held constant; a dispatch while BUSY is ignored; CDB(tag 2) changes nothing.
//  5. Reset: RST pulse while in WAIT ->
//     BUSY=0 and FU_VALID=0 immediately; a later CDB match has no effect.
//  6. RS_FLUSH_EN build: FLUSH while READY with FU_READY=1 ->
//     state IDLE, no further FU_VALID; a new dispatch is accepted next cycle.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// Shared CPU types for the Tomasulo back end: RS tags, opcodes, station states, operand record.
package cpu_types;

    localparam int RS_TAG_W = 3;
    localparam int RS_XLEN  = 32;

    typedef enum logic [RS_TAG_W-1:0] {
        STORE_1 = 3'd0,
        STORE_2 = 3'd1,
        LOAD_1  = 3'd2,
        LOAD_2  = 3'd3,
        ALU_1   = 3'd4,
        ALU_2   = 3'd5,
        INVALID = 3'd7
    } RS_tag_type;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_ALU   = 7'b0110011;
    localparam logic [6:0] OPC_ALUI  = 7'b0010011;

    // Kept as plain constants so older tools and waveform scripts see fixed encodings.
    typedef logic [1:0] rs_state_t;
    localparam rs_state_t IDLE  = 2'd0;
    localparam rs_state_t WAIT  = 2'd1;
    localparam rs_state_t READY = 2'd2;

    typedef struct packed {
        logic                rdy;
        logic [RS_TAG_W-1:0] tag;
        logic [RS_XLEN-1:0]  val;
    } operand_t;

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch, CDB and FU-side signals of one reservation station.
interface rs_if #(
    parameter int TAG_W = 3,
    parameter int XLEN  = 32
);
    logic             DISP_VALID;
    logic [TAG_W-1:0] DEST_RS;
    logic [10:0]      DISP_OP;
    logic [TAG_W-1:0] DISP_DST;
    logic [TAG_W-1:0] DISP_Q1, DISP_Q2;
    logic             DISP_R1, DISP_R2;
    logic [XLEN-1:0]  DISP_V1, DISP_V2;
    logic             CDB_VALID;
    logic [TAG_W-1:0] CDB_TAG;
    logic [XLEN-1:0]  CDB_DATA;
    logic             FU_READY;
    logic             FU_VALID;
    logic [10:0]      FU_OP;
    logic [XLEN-1:0]  FU_A, FU_B;
    logic [TAG_W-1:0] FU_DST;
    logic             BUSY;

    modport master (
        output DISP_VALID, DEST_RS, DISP_OP, DISP_DST, DISP_Q1, DISP_Q2,
               DISP_R1, DISP_R2, DISP_V1, DISP_V2, CDB_VALID, CDB_TAG, CDB_DATA, FU_READY,
        input  FU_VALID, FU_OP, FU_A, FU_B, FU_DST, BUSY
    );

    modport slave (
        input  DISP_VALID, DEST_RS, DISP_OP, DISP_DST, DISP_Q1, DISP_Q2,
               DISP_R1, DISP_R2, DISP_V1, DISP_V2, CDB_VALID, CDB_TAG, CDB_DATA, FU_READY,
        output FU_VALID, FU_OP, FU_A, FU_B, FU_DST, BUSY
    );
endinterface

// File: rtl/reservation_station_slot.sv
// One source operand: captures at dispatch (value, CDB bypass, or tag) and snoops the CDB while waiting.
module rs_operand_slot #(
    parameter int TAG_W = 3,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_i,
    input  logic             snoop_i,
    input  logic             r_i,
    input  logic [XLEN-1:0]  v_i,
    input  logic [TAG_W-1:0] q_i,
    input  logic             cdb_valid_i,
    input  logic [TAG_W-1:0] cdb_tag_i,
    input  logic [XLEN-1:0]  cdb_data_i,
    output logic             rdy_o,
    output logic             rdy_next_o,
    output logic [XLEN-1:0]  val_o
);
    typedef struct packed {
        logic             rdy;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  val;
    } slot_t;

    slot_t opnd_q, opnd_d;

    always_comb begin
        opnd_d = opnd_q;
        if (cap_i) begin
            opnd_d.tag = q_i;
            if (r_i) begin
                opnd_d.rdy = 1'b1;
                opnd_d.val = v_i;
            end else if (cdb_valid_i && cdb_tag_i == q_i) begin
                opnd_d.rdy = 1'b1;
                opnd_d.val = cdb_data_i;
            end else begin
                opnd_d.rdy = 1'b0;
                opnd_d.val = '0;
            end
        end else if (snoop_i && !opnd_q.rdy && cdb_valid_i && cdb_tag_i == opnd_q.tag) begin
            opnd_d.rdy = 1'b1;
            opnd_d.val = cdb_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) opnd_q <= '0;
        else     opnd_q <= opnd_d;
    end

    assign rdy_o      = opnd_q.rdy;
    assign rdy_next_o = opnd_d.rdy;
    assign val_o      = opnd_q.val;
endmodule

// File: rtl/reservation_station.sv
// Single-entry Tomasulo reservation station: accept, CDB snoop, FU issue handshake.
// Optional RS_FLUSH_EN adds a synchronous FLUSH input that empties the entry.
module reservation_station
    import cpu_types::*;
#(
    parameter int RS_ID = 4,
    parameter int TAG_W = 3,
    parameter int XLEN  = 32
) (
    input  logic CLK,
    input  logic RST,
`ifdef RS_FLUSH_EN
    input  logic FLUSH,
`endif
    rs_if.slave  bus
);
    localparam logic [TAG_W-1:0] MY_TAG = TAG_W'(RS_ID);

    rs_state_t   state_q, state_d;
    logic        fu_valid_q, fu_valid_d;
    logic [10:0] op_q, op_d;
    logic [TAG_W-1:0] dst_q, dst_d;
    logic        flush;
    logic        accept, handshake, snoop;
    logic [1:0]  rdy, rdy_next;
    logic [1:0][XLEN-1:0] val;

`ifdef RS_FLUSH_EN
    assign flush = FLUSH;
`else
    assign flush = 1'b0;
`endif

    assign accept    = bus.DISP_VALID && bus.DEST_RS == MY_TAG && state_q == IDLE && !flush;
    assign handshake = fu_valid_q && bus.FU_READY;
    assign snoop     = state_q == WAIT && !flush;

    rs_operand_slot #(.TAG_W(TAG_W), .XLEN(XLEN)) u_src1 (
        .clk(CLK), .rst(RST), .cap_i(accept), .snoop_i(snoop),
        .r_i(bus.DISP_R1), .v_i(bus.DISP_V1), .q_i(bus.DISP_Q1),
        .cdb_valid_i(bus.CDB_VALID), .cdb_tag_i(bus.CDB_TAG), .cdb_data_i(bus.CDB_DATA),
        .rdy_o(rdy[0]), .rdy_next_o(rdy_next[0]), .val_o(val[0])
    );

    rs_operand_slot #(.TAG_W(TAG_W), .XLEN(XLEN)) u_src2 (
        .clk(CLK), .rst(RST), .cap_i(accept), .snoop_i(snoop),
        .r_i(bus.DISP_R2), .v_i(bus.DISP_V2), .q_i(bus.DISP_Q2),
        .cdb_valid_i(bus.CDB_VALID), .cdb_tag_i(bus.CDB_TAG), .cdb_data_i(bus.CDB_DATA),
        .rdy_o(rdy[1]), .rdy_next_o(rdy_next[1]), .val_o(val[1])
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dst_d   = dst_q;
        case (state_q)
            IDLE:  if (accept) begin
                       op_d    = bus.DISP_OP;
                       dst_d   = bus.DISP_DST;
                       state_d = (&rdy_next) ? READY : WAIT;
                   end
            // Ready bits are looked at post-capture so the last CDB edge also lands in READY.
            WAIT:  if (&rdy_next) state_d = READY;
            READY: if (handshake) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
        fu_valid_d = state_d == READY;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            fu_valid_q <= 1'b0;
            op_q       <= '0;
            dst_q      <= '0;
        end else begin
            state_q    <= state_d;
            fu_valid_q <= fu_valid_d;
            op_q       <= op_d;
            dst_q      <= dst_d;
        end
    end

    // rdy is implied by state; only the values are forwarded.
    logic unused_rdy;
    assign unused_rdy = ^rdy;

    assign bus.FU_VALID = fu_valid_q;
    assign bus.FU_OP    = op_q;
    assign bus.FU_A     = val[0];
    assign bus.FU_B     = val[1];
    assign bus.FU_DST   = dst_q;
    assign bus.BUSY     = state_q != IDLE;
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with a per-cycle behavioural model (RS_FLUSH_EN optional).
module tb_reservation_station;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rs_if #(.TAG_W(3), .XLEN(32)) bus ();
`ifdef RS_FLUSH_EN
    logic flush = 1'b0;
`endif

    reservation_station #(.RS_ID(4), .TAG_W(3), .XLEN(32)) dut (
        .CLK(clk), .RST(rst),
`ifdef RS_FLUSH_EN
        .FLUSH(flush),
`endif
        .bus(bus)
    );

    int total = 0;
    int bad = 0;

    // Model: an entry is either empty or holds one task whose operands are known or pending.
    bit          m_busy;
    bit          m_rdy [2];
    logic [2:0]  m_tag [2];
    logic [31:0] m_val [2];
    logic [10:0] m_op;
    logic [2:0]  m_dst;

    function automatic bit m_issuing();
        return m_busy && m_rdy[0] && m_rdy[1];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_busy = 0; m_op = '0; m_dst = '0;
        for (int i = 0; i < 2; i++) begin m_rdy[i] = 0; m_tag[i] = '0; m_val[i] = '0; end
    endtask

    task automatic m_edge();
        bit fl;
        bit r [2];
        logic [2:0]  q [2];
        logic [31:0] v [2];
        fl = 0;
`ifdef RS_FLUSH_EN
        fl = flush;
`endif
        r[0] = bus.DISP_R1; r[1] = bus.DISP_R2;
        q[0] = bus.DISP_Q1; q[1] = bus.DISP_Q2;
        v[0] = bus.DISP_V1; v[1] = bus.DISP_V2;
        if (rst) m_reset();
        else if (fl) m_busy = 0;
        else if (!m_busy) begin
            if (bus.DISP_VALID && bus.DEST_RS == 3'd4) begin
                m_busy = 1; m_op = bus.DISP_OP; m_dst = bus.DISP_DST;
                for (int i = 0; i < 2; i++) begin
                    m_tag[i] = q[i];
                    if (r[i]) begin m_rdy[i] = 1; m_val[i] = v[i]; end
                    else if (bus.CDB_VALID && bus.CDB_TAG == q[i]) begin m_rdy[i] = 1; m_val[i] = bus.CDB_DATA; end
                    else begin m_rdy[i] = 0; m_val[i] = '0; end
                end
            end
        end else if (m_issuing()) begin
            if (bus.FU_READY) m_busy = 0;
        end else begin
            for (int i = 0; i < 2; i++)
                if (!m_rdy[i] && bus.CDB_VALID && bus.CDB_TAG == m_tag[i]) begin
                    m_rdy[i] = 1; m_val[i] = bus.CDB_DATA;
                end
        end
    endtask

    task automatic compare();
        chk("busy", 32'(bus.BUSY), 32'(m_busy));
        chk("fu_valid", 32'(bus.FU_VALID), 32'(m_issuing()));
        if (m_issuing()) begin
            chk("fu_op", 32'(bus.FU_OP), 32'(m_op));
            chk("fu_a", bus.FU_A, m_val[0]);
            chk("fu_b", bus.FU_B, m_val[1]);
            chk("fu_dst", 32'(bus.FU_DST), 32'(m_dst));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        m_edge();
        #1;
        compare();
    endtask

    task automatic quiet();
        bus.DISP_VALID = 0; bus.DEST_RS = '0; bus.DISP_OP = '0; bus.DISP_DST = '0;
        bus.DISP_Q1 = '0; bus.DISP_Q2 = '0; bus.DISP_R1 = 0; bus.DISP_R2 = 0;
        bus.DISP_V1 = '0; bus.DISP_V2 = '0;
        bus.CDB_VALID = 0; bus.CDB_TAG = '0; bus.CDB_DATA = '0;
    endtask

    task automatic disp(input logic [2:0] dest, input logic [10:0] op,
                        input bit r1, input logic [2:0] q1, input logic [31:0] v1,
                        input bit r2, input logic [2:0] q2, input logic [31:0] v2);
        bus.DISP_VALID = 1; bus.DEST_RS = dest; bus.DISP_OP = op; bus.DISP_DST = 3'd4;
        bus.DISP_R1 = r1; bus.DISP_Q1 = q1; bus.DISP_V1 = v1;
        bus.DISP_R2 = r2; bus.DISP_Q2 = q2; bus.DISP_V2 = v2;
    endtask

    task automatic cdb(input logic [2:0] tag, input logic [31:0] data);
        bus.CDB_VALID = 1; bus.CDB_TAG = tag; bus.CDB_DATA = data;
    endtask

    initial begin
        quiet();
        bus.FU_READY = 0;
        m_reset();
        cyc();
        chk("reset_fu_a", bus.FU_A, 32'h0);
        chk("reset_fu_op", 32'(bus.FU_OP), 32'h0);
        rst = 0;
        cyc();

        // Foreign target while idle is not taken.
        disp(3'd2, 11'h7ff, 1, 3'd0, 32'd1, 1, 3'd0, 32'd2);
        cyc(); quiet();
        chk("foreign_busy", 32'(bus.BUSY), 32'd0);

        // Both operands ready on dispatch.
        disp(3'd4, {cpu_types::OPC_ALU, 4'h3}, 1, 3'd0, 32'd5, 1, 3'd0, 32'd7);
        cyc(); quiet();
        chk("t1_busy", 32'(bus.BUSY), 32'd1);
        chk("t1_valid", 32'(bus.FU_VALID), 32'd1);
        chk("t1_a", bus.FU_A, 32'd5);
        chk("t1_b", bus.FU_B, 32'd7);
        bus.FU_READY = 1;
        cyc();
        bus.FU_READY = 0;
        chk("t1_free", 32'(bus.BUSY), 32'd0);

        // src1 waits on tag 2; a wrong-tag broadcast is ignored.
        disp(3'd4, 11'h155, 0, 3'd2, 32'hdead, 1, 3'd0, 32'd9);
        cyc(); quiet();
        chk("t2_wait", 32'(bus.FU_VALID), 32'd0);
        cdb(3'd5, 32'hbad); cyc(); quiet();
        cyc(); cyc();
        cdb(3'd2, 32'h1234); cyc(); quiet();
        chk("t2_valid", 32'(bus.FU_VALID), 32'd1);
        chk("t2_a", bus.FU_A, 32'h1234);
        // Dispatch held during the handshake must not be taken in the same edge.
        bus.FU_READY = 1;
        disp(3'd4, 11'h0aa, 1, 3'd0, 32'd11, 1, 3'd0, 32'd12);
        cyc();
        bus.FU_READY = 0;
        chk("reuse_gap", 32'(bus.BUSY), 32'd0);
        cyc(); quiet();
        chk("reuse_next", 32'(bus.BUSY), 32'd1);
        bus.FU_READY = 1; cyc(); bus.FU_READY = 0;

        // Bypass from the CDB in the dispatch cycle, then backpressure.
        disp(3'd4, 11'h321, 0, 3'd3, 32'h0, 0, 3'd3, 32'h0);
        cdb(3'd3, 32'hAA);
        cyc(); quiet();
        chk("t3_a", bus.FU_A, 32'hAA);
        chk("t3_b", bus.FU_B, 32'hAA);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) disp(3'd4, 11'h111, 1, 3'd0, 32'h55, 1, 3'd0, 32'h66);
            if (i == 2) cdb(3'd2, 32'h9999);
            cyc(); quiet();
            chk("t4_hold_a", bus.FU_A, 32'hAA);
            chk("t4_hold_op", 32'(bus.FU_OP), 32'h321);
        end
        bus.FU_READY = 1; cyc(); bus.FU_READY = 0;

        // Shared producer tag resolves both operands in one broadcast.
        disp(3'd4, 11'h042, 0, 3'd6, 32'h0, 0, 3'd6, 32'h0);
        cyc(); quiet();
        cdb(3'd6, 32'hcafe); cyc(); quiet();
        chk("qq_b", bus.FU_B, 32'hcafe);
        bus.FU_READY = 1; cyc(); bus.FU_READY = 0;

        // Asynchronous reset while waiting.
        disp(3'd4, 11'h0f0, 0, 3'd1, 32'h0, 1, 3'd0, 32'h3);
        cyc(); quiet();
        #2 rst = 1;
        #1;
        chk("t5_busy", 32'(bus.BUSY), 32'd0);
        chk("t5_valid", 32'(bus.FU_VALID), 32'd0);
        m_reset();
        #1 rst = 0;
        cdb(3'd1, 32'h77); cyc(); quiet();
        cyc();
        chk("t5_after", 32'(bus.FU_VALID), 32'd0);

`ifdef RS_FLUSH_EN
        disp(3'd4, 11'h00f, 1, 3'd0, 32'd1, 1, 3'd0, 32'd2);
        cyc(); quiet();
        bus.FU_READY = 1; flush = 1;
        cyc();
        flush = 0; bus.FU_READY = 0;
        chk("t6_flushed", 32'(bus.FU_VALID), 32'd0);
        disp(3'd4, 11'h0ff, 1, 3'd0, 32'd3, 1, 3'd0, 32'd4);
        cyc(); quiet();
        chk("t6_accept", 32'(bus.BUSY), 32'd1);
        bus.FU_READY = 1; cyc(); bus.FU_READY = 0;
`endif
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
